// File: rtl/mbc_mem_pkg.sv
// Shared definitions for the single-port memory and its bus-master front end.
// MEM_WRITE_VERIFY_EN adds the verify re-read state encoding.
package mbc_mem_pkg;

    localparam int MEM_ADDR_W = 12;
    localparam int MEM_DATA_W = 16;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT      = 3'd2;
    localparam logic [2:0] ST_RESP      = 3'd3;
`ifdef MEM_WRITE_VERIFY_EN
    localparam logic [2:0] ST_VFY_ISSUE = 3'd4;
`endif

endpackage

// File: rtl/memory_requester.sv
// Valid/ready front end that issues one read or write at a time to the synchronous memory.
// Define MEM_WRITE_VERIFY_EN to re-read every write and flag a read-back mismatch.
module memory_requester
    import mbc_mem_pkg::*;
#(
    parameter int A = MEM_ADDR_W,
    parameter int D = MEM_DATA_W
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [A-1:0] req_address,
    input  logic [D-1:0] req_data,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [D-1:0] resp_data,
    output logic         resp_error,
    output logic [A-1:0] mem_address,
    output logic         mem_write_enable,
    output logic [D-1:0] mem_write_data,
    input  logic [D-1:0] mem_read_data
);

    logic [2:0]   state_q, state_d;
    logic [A-1:0] addr_q, addr_d;
    logic         we_q, we_d;
    logic [D-1:0] wdata_q, wdata_d;
    logic [D-1:0] rdata_q, rdata_d;
    logic         rvalid_q, rvalid_d;
`ifdef MEM_WRITE_VERIFY_EN
    logic         write_q, write_d;
    logic         error_q, error_d;
`endif

    // Memory pins come straight from flops so the write strobe is never decoded.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
`ifdef MEM_WRITE_VERIFY_EN
        write_d  = write_q;
        error_d  = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_address;
                    we_d    = req_write;
                    if (req_write) begin
                        wdata_d = req_data;
                    end
`ifdef MEM_WRITE_VERIFY_EN
                    write_d = req_write;
`endif
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                we_d = 1'b0;
`ifdef MEM_WRITE_VERIFY_EN
                state_d = write_q ? ST_VFY_ISSUE : ST_WAIT;
`else
                state_d = ST_WAIT;
`endif
            end
`ifdef MEM_WRITE_VERIFY_EN
            ST_VFY_ISSUE: begin
                state_d = ST_WAIT;
            end
`endif
            ST_WAIT: begin
                rdata_d  = mem_read_data;
                rvalid_d = 1'b1;
`ifdef MEM_WRITE_VERIFY_EN
                error_d  = write_q && (mem_read_data != wdata_q);
`endif
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef MEM_WRITE_VERIFY_EN
            write_q  <= 1'b0;
            error_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef MEM_WRITE_VERIFY_EN
            write_q  <= write_d;
            error_q  <= error_d;
`endif
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = rvalid_q;
    assign resp_data        = rdata_q;
    assign mem_address      = addr_q;
    assign mem_write_enable = we_q;
    assign mem_write_data   = wdata_q;
`ifdef MEM_WRITE_VERIFY_EN
    assign resp_error       = error_q;
`else
    assign resp_error       = 1'b0;
`endif

endmodule

// File: tb/tb_memory_requester.sv
// Bench for memory_requester with a behavioural memory preloaded as mem[a] = a ^ 16'hA5A5.
// Expectations follow MEM_WRITE_VERIFY_EN the same way the design does.
module tb_memory_requester;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_address;
    logic [15:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic        resp_error;
    logic [11:0] mem_address;
    logic        mem_write_enable;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;

    logic [15:0] mem    [0:4095];
    logic [15:0] refMem [0:4095];
    logic [15:0] memRdQ;
    logic        flipBit;

    typedef struct {
        logic [15:0] data;
        logic        err;
        int          lat;
        int          stamp;
    } exp_t;

    exp_t expQ[$];
    int   respCycles[$];
    int   cycleCnt = 0;
    int   weCount  = 0;
    int   testsRun = 0;
    int   failCount = 0;
    logic respSeen;

    memory_requester #(.A(12), .D(16)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_address      (req_address),
        .req_data         (req_data),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_error       (resp_error),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cycleCnt <= cycleCnt + 1;

    // Registered read, read-before-write; flipBit corrupts bit 0 of the read port.
    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]    = 16'(i) ^ 16'hA5A5;
            refMem[i] = 16'(i) ^ 16'hA5A5;
        end
        forever begin
            @(posedge clock);
            memRdQ <= mem[mem_address];
            if (mem_write_enable) mem[mem_address] <= mem_write_data;
        end
    end

    assign mem_read_data = memRdQ ^ {15'b0, flipBit};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: scoreboard push on accept, latency check on first resp_valid, pop on handshake.
    always begin
        @(negedge clock);
        #2;
        if (!reset_n) begin
            respSeen = 1'b0;
        end else begin
            if (mem_write_enable) weCount++;
            if (req_valid && req_ready) begin
                exp_t e;
                e.stamp = cycleCnt + 1;
                e.lat   = 2;
                e.err   = 1'b0;
                if (req_write) begin
`ifdef MEM_WRITE_VERIFY_EN
                    e.data = req_data ^ {15'b0, flipBit};
                    e.err  = flipBit;
                    e.lat  = 3;
`else
                    e.data = refMem[req_address];
`endif
                    refMem[req_address] = req_data;
                end else begin
                    e.data = refMem[req_address];
                end
                expQ.push_back(e);
            end
            if (resp_valid && !respSeen) begin
                respSeen = 1'b1;
                if (expQ.size() == 0) checkOutput("unexpectedResp", 32'(resp_data), 32'hFFFF_FFFF);
                else checkOutput("latency", 32'(cycleCnt - expQ[0].stamp), 32'(expQ[0].lat));
            end
            if (resp_valid && resp_ready && expQ.size() != 0) begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("respData", 32'(resp_data), 32'(e.data));
                checkOutput("respError", 32'(resp_error), 32'(e.err));
                respCycles.push_back(cycleCnt);
                respSeen = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge with req_valid low.
    task automatic applyStimulus(input logic wr, input logic [11:0] addr, input logic [15:0] data);
        bit accepted = 1'b0;
        req_valid   = 1'b1;
        req_write   = wr;
        req_address = addr;
        req_data    = data;
        for (int i = 0; i < 40 && !accepted; i++) begin
            #1;
            if (req_ready) accepted = 1'b1;
            else @(negedge clock);
        end
        if (!accepted) checkOutput("acceptTimeout", 32'd0, 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (expQ.size() == 0 && !resp_valid && req_ready) done = 1'b1;
            else @(negedge clock);
        end
        if (!done) checkOutput("idleTimeout", 32'd0, 32'd1);
    endtask

    initial begin
        int weBefore;
        int n0;
        logic [15:0] held;
        logic [11:0] addrHeld;
        logic [15:0] saved;
        bit seen;

        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = '0;
        req_data    = '0;
        resp_ready  = 1'b1;
        flipBit     = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("rstReqReady", 32'(req_ready), 32'd1);
        checkOutput("rstRespValid", 32'(resp_valid), 32'd0);
        checkOutput("rstRespError", 32'(resp_error), 32'd0);
        checkOutput("rstRespData", 32'(resp_data), 32'd0);
        checkOutput("rstMemWe", 32'(mem_write_enable), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Plain read of 0x005.
        applyStimulus(1'b0, 12'h005, 16'h0000);
        waitIdle();

        // Write then read back; strobe must last exactly one cycle.
        weBefore = weCount;
        applyStimulus(1'b1, 12'h005, 16'h1234);
        waitIdle();
        checkOutput("weCycles", 32'(weCount - weBefore), 32'd1);
        applyStimulus(1'b0, 12'h005, 16'h0000);
        waitIdle();

        // Back-pressure: response held stable with no memory activity.
        resp_ready = 1'b0;
        applyStimulus(1'b0, 12'h123, 16'h0000);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (resp_valid) seen = 1'b1;
            else @(negedge clock);
        end
        checkOutput("holdRespSeen", 32'(seen), 32'd1);
        held     = resp_data;
        addrHeld = mem_address;
        checkOutput("holdData0", 32'(held), 32'hA486);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            #1;
            checkOutput("holdValid", 32'(resp_valid), 32'd1);
            checkOutput("holdData", 32'(resp_data), 32'(held));
            checkOutput("holdReqReady", 32'(req_ready), 32'd0);
            checkOutput("holdMemWe", 32'(mem_write_enable), 32'd0);
            checkOutput("holdMemAddr", 32'(mem_address), 32'(addrHeld));
        end
        resp_ready = 1'b1;
        @(negedge clock);
        waitIdle();

        // Three queued reads with req_valid kept high between them.
        n0 = respCycles.size();
        applyStimulus(1'b0, 12'h000, 16'h0000);
        applyStimulus(1'b0, 12'hFFF, 16'h0000);
        applyStimulus(1'b0, 12'h800, 16'h0000);
        waitIdle();
        checkOutput("burstCount", 32'(respCycles.size() - n0), 32'd3);
        if (respCycles.size() - n0 == 3) begin
            checkOutput("burstGap1", 32'(respCycles[n0+1] - respCycles[n0]), 32'd4);
            checkOutput("burstGap2", 32'(respCycles[n0+2] - respCycles[n0+1]), 32'd4);
        end

        // Reset during ISSUE of a write aborts it.
        saved       = refMem[12'h010];
        req_valid   = 1'b1;
        req_write   = 1'b1;
        req_address = 12'h010;
        req_data    = 16'hBEEF;
        #1;
        checkOutput("abortAccept", 32'(req_ready), 32'd1);
        @(negedge clock);
        req_valid = 1'b0;
        #1;
        checkOutput("abortInIssue", 32'(mem_write_enable), 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("abortMemWe", 32'(mem_write_enable), 32'd0);
        checkOutput("abortReqReady", 32'(req_ready), 32'd1);
        checkOutput("abortMemAddr", 32'(mem_address), 32'd0);
        checkOutput("abortMemWdata", 32'(mem_write_data), 32'd0);
        checkOutput("abortRespValid", 32'(resp_valid), 32'd0);
        expQ.delete();
        refMem[12'h010] = saved;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        applyStimulus(1'b0, 12'h010, 16'h0000);
        waitIdle();

`ifdef MEM_WRITE_VERIFY_EN
        // Corrupted read-back flags an error; a clean write does not.
        flipBit = 1'b1;
        applyStimulus(1'b1, 12'h020, 16'h5A5A);
        waitIdle();
        flipBit = 1'b0;
        applyStimulus(1'b1, 12'h021, 16'h0F0F);
        waitIdle();
`endif

        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
